wbs_kdtree_loader_ctrl: RTL and testbench

//  Wishbone slave controller that sequences host access to the KD-tree ANN accelerator.
//  - Decodes 32-bit Wishbone accesses into control/status registers, internal-node writes,

---
 rtl/wbs_kdtree_loader_ctrl.sv | 272 +++++++++++++++++++++++++++
 tb/tb_wbs_kdtree_loader_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbs_kdtree_loader_ctrl.sv
// wbs_kdtree_loader_ctrl
//   Wishbone slave that gives the host access to the KD-tree ANN accelerator.
//   It decodes 32-bit accesses into control/status registers, internal-node
//   writes, leaf/query 64-bit entry writes (assembled from two 32-bit halves)
//   and best-array reads.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   S_IDLE    | waiting for cyc&stb; the access is performed on the sampling edge
//   S_RD_WAIT | best-array read issued, counting down BEST_RD_LAT cycles
//   S_ACK     | ack driven for one cycle (suppressed if the master has let go)
//   S_RECOVER | one dead cycle so a master still holding stb is not acked twice
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i        Wishbone cycle, strobe, write enable
//   wbs_sel_i                   byte selects (ignored, full-word only)
//   wbs_adr_i, wbs_dat_i        byte address, write data
//   wbs_ack_o, wbs_dat_o        acknowledge, read data (valid with ack)
//   mode_o, debug_o             mode / debug register bit 0
//   fsm_start_o                 one-cycle start pulse to the main FSM
//   fsm_busy_i, fsm_done_i      main FSM status
//   node_we_o/idx_o/wdata_o     internal-node memory write port
//   leaf_we_o, query_we_o       leaf / query entry write strobes
//   entry_addr_o, entry_wdata_o shared leaf/query entry index and data
//   best_re_o, best_addr_o      best-array read request
//   best_rdata_i                best-array data, BEST_RD_LAT cycles after best_re_o

module wbs_kdtree_loader_ctrl #(
  parameter int          DATA_WIDTH  = 11,
  parameter int          NUM_NODES   = 63,
  parameter int          NUM_LEAVES  = 64,
  parameter int          NUM_QUERYS  = 494,
  parameter int          BEST_RD_LAT = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  wbs_cyc_i,
  input  logic                                  wbs_stb_i,
  input  logic                                  wbs_we_i,
  input  logic [3:0]                            wbs_sel_i,
  input  logic [31:0]                           wbs_adr_i,
  input  logic [31:0]                           wbs_dat_i,
  output logic                                  wbs_ack_o,
  output logic [31:0]                           wbs_dat_o,
  output logic                                  mode_o,
  output logic                                  debug_o,
  output logic                                  fsm_start_o,
  input  logic                                  fsm_busy_i,
  input  logic                                  fsm_done_i,
  output logic                                  node_we_o,
  output logic [$clog2(NUM_NODES+1)-1:0]        node_idx_o,
  output logic [2*DATA_WIDTH-1:0]               node_wdata_o,
  output logic                                  leaf_we_o,
  output logic                                  query_we_o,
  output logic [$clog2(NUM_LEAVES*8)-1:0]       entry_addr_o,
  output logic [63:0]                           entry_wdata_o,
  output logic                                  best_re_o,
  output logic [$clog2(NUM_QUERYS)-1:0]         best_addr_o,
  input  logic [63:0]                           best_rdata_i
);

  localparam int NODE_IDX_W  = $clog2(NUM_NODES+1);
  localparam int NUM_ENTRIES = NUM_LEAVES*8;
  localparam int LEAF_IDX_W  = $clog2(NUM_ENTRIES);
  localparam int QUERY_IDX_W = $clog2(NUM_QUERYS);
  // Holds BEST_RD_LAT-1, the countdown start value.
  localparam int CNT_W       = (BEST_RD_LAT > 1) ? $clog2(BEST_RD_LAT) : 1;

  localparam logic [3:0] RG_CTRL  = 4'd0;
  localparam logic [3:0] RG_QUERY = 4'd1;
  localparam logic [3:0] RG_LEAF  = 4'd2;
  localparam logic [3:0] RG_BEST  = 4'd3;
  localparam logic [3:0] RG_NODE  = 4'd4;

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_ACK, S_RECOVER} state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                   mode_q, debug_q, seq_err_q;
  logic                   hold_valid_q, hold_leaf_q;
  logic [LEAF_IDX_W-1:0]  hold_idx_q;
  logic [31:0]            hold_lo_q;
  logic [31:0]            rd_data_q;
  logic                   best_hit_q, half_q, abort_q;

  logic                   req, base_hit, best_rd, is_leaf, half;
  logic [3:0]             region;
  logic [NODE_IDX_W-1:0]  node_idx;
  logic [LEAF_IDX_W-1:0]  leaf_idx, ent_idx;
  logic [QUERY_IDX_W-1:0] query_idx;
  logic                   node_ok, leaf_ok, query_ok, ent_ok;

  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i, wbs_adr_i};

  assign req       = (state_q == S_IDLE) && wbs_cyc_i && wbs_stb_i;
  assign base_hit  = (wbs_adr_i[31:20] == BASE_ADDR[31:20]);
  assign region    = wbs_adr_i[19:16];
  assign half      = wbs_adr_i[2];
  assign best_rd   = base_hit && (region == RG_BEST) && !wbs_we_i;

  assign node_idx  = wbs_adr_i[NODE_IDX_W+1:2];
  assign leaf_idx  = wbs_adr_i[LEAF_IDX_W+2:3];
  assign query_idx = wbs_adr_i[QUERY_IDX_W+2:3];
  assign node_ok   = int'(node_idx)  < NUM_NODES;
  assign leaf_ok   = int'(leaf_idx)  < NUM_ENTRIES;
  assign query_ok  = int'(query_idx) < NUM_QUERYS;

  // Leaf and query share one entry port and one lower-half holding register;
  // the region tag in the holding register keeps their halves from pairing.
  assign is_leaf   = (region == RG_LEAF);
  assign ent_idx   = is_leaf ? leaf_idx : LEAF_IDX_W'(query_idx);
  assign ent_ok    = is_leaf ? leaf_ok : query_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (best_rd) begin
            state_d = S_RD_WAIT;
            cnt_d   = CNT_W'(BEST_RD_LAT-1);
          end else begin
            state_d = S_ACK;
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) state_d = S_ACK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ACK:     state_d = S_RECOVER;
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q        <= 1'b0;
      debug_q       <= 1'b0;
      seq_err_q     <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_leaf_q   <= 1'b0;
      hold_idx_q    <= '0;
      hold_lo_q     <= '0;
      rd_data_q     <= '0;
      best_hit_q    <= 1'b0;
      half_q        <= 1'b0;
      abort_q       <= 1'b0;
      fsm_start_o   <= 1'b0;
      node_we_o     <= 1'b0;
      node_idx_o    <= '0;
      node_wdata_o  <= '0;
      leaf_we_o     <= 1'b0;
      query_we_o    <= 1'b0;
      entry_addr_o  <= '0;
      entry_wdata_o <= '0;
      best_re_o     <= 1'b0;
      best_addr_o   <= '0;
    end else begin
      fsm_start_o <= 1'b0;
      node_we_o   <= 1'b0;
      leaf_we_o   <= 1'b0;
      query_we_o  <= 1'b0;
      best_re_o   <= 1'b0;

      // Master let go while the best read was in flight: finish quietly.
      if ((state_q == S_RD_WAIT) && !(wbs_cyc_i && wbs_stb_i)) abort_q <= 1'b1;

      if (req) begin
        abort_q    <= 1'b0;
        rd_data_q  <= '0;
        best_hit_q <= 1'b0;
        half_q     <= half;
        if (base_hit) begin
          case (region)
            RG_CTRL: begin
              if (wbs_we_i) begin
                case (wbs_adr_i[7:0])
                  8'h00: mode_q  <= wbs_dat_i[0];
                  8'h04: debug_q <= wbs_dat_i[0];
                  8'h0C: if (!fsm_busy_i) fsm_start_o <= 1'b1;
                  8'h14: if (wbs_dat_i[0]) seq_err_q <= 1'b0;
                  default: ;
                endcase
              end else begin
                case (wbs_adr_i[7:0])
                  8'h00: rd_data_q <= {31'b0, mode_q};
                  8'h04: rd_data_q <= {31'b0, debug_q};
                  8'h08: rd_data_q <= {31'b0, fsm_done_i};
                  8'h10: rd_data_q <= {31'b0, fsm_busy_i};
                  8'h14: rd_data_q <= {31'b0, seq_err_q};
                  default: ;
                endcase
              end
            end
            RG_NODE: begin
              if (wbs_we_i && node_ok) begin
                if (fsm_busy_i) begin
                  seq_err_q <= 1'b1;
                end else begin
                  node_we_o    <= 1'b1;
                  node_idx_o   <= node_idx;
                  node_wdata_o <= wbs_dat_i[2*DATA_WIDTH-1:0];
                end
              end
            end
            RG_QUERY, RG_LEAF: begin
              if (wbs_we_i && ent_ok) begin
                if (fsm_busy_i) begin
                  seq_err_q <= 1'b1;
                end else if (!half) begin
                  hold_valid_q <= 1'b1;
                  hold_leaf_q  <= is_leaf;
                  hold_idx_q   <= ent_idx;
                  hold_lo_q    <= wbs_dat_i;
                end else if (hold_valid_q && (hold_idx_q == ent_idx) && (hold_leaf_q == is_leaf)) begin
                  leaf_we_o     <= is_leaf;
                  query_we_o    <= !is_leaf;
                  entry_addr_o  <= ent_idx;
                  entry_wdata_o <= {wbs_dat_i, hold_lo_q};
                  hold_valid_q  <= 1'b0;
                end else begin
                  seq_err_q <= 1'b1;
                end
              end
            end
            RG_BEST: begin
              if (!wbs_we_i && query_ok) begin
                best_re_o   <= 1'b1;
                best_addr_o <= query_idx;
                best_hit_q  <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign mode_o  = mode_q;
  assign debug_o = debug_q;

  assign wbs_ack_o = (state_q == S_ACK) && wbs_cyc_i && wbs_stb_i && !abort_q;

  // Best data is taken straight from the array in the ack cycle, which is
  // exactly BEST_RD_LAT cycles after the read strobe.
  always_comb begin
    wbs_dat_o = '0;
    if (wbs_ack_o) begin
      if (best_hit_q) wbs_dat_o = half_q ? best_rdata_i[63:32] : best_rdata_i[31:0];
      else            wbs_dat_o = rd_data_q;
    end
  end

endmodule

// File: tb/tb_wbs_kdtree_loader_ctrl.sv
module tb_wbs_kdtree_loader_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic        mode, debug, start, busy, done;
  logic        node_we;
  logic [5:0]  node_idx;
  logic [21:0] node_wdata;
  logic        leaf_we, query_we;
  logic [8:0]  entry_addr;
  logic [63:0] entry_wdata;
  logic        best_re;
  logic [8:0]  best_addr;
  logic [63:0] best_rdata;

  always #5 clk = ~clk;

  wbs_kdtree_loader_ctrl #(.BEST_RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .mode_o(mode), .debug_o(debug), .fsm_start_o(start),
    .fsm_busy_i(busy), .fsm_done_i(done),
    .node_we_o(node_we), .node_idx_o(node_idx), .node_wdata_o(node_wdata),
    .leaf_we_o(leaf_we), .query_we_o(query_we),
    .entry_addr_o(entry_addr), .entry_wdata_o(entry_wdata),
    .best_re_o(best_re), .best_addr_o(best_addr), .best_rdata_i(best_rdata)
  );

  // best-array memory with LAT register stages
  logic [63:0] best_mem [512];
  logic [63:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    if (best_re) p1 <= best_mem[best_addr];
    p2 <= p1;
  end
  assign best_rdata = p2;

  int n_chk = 0, n_pass = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // event monitor (sampled on the falling edge)
  int node_cnt = 0, leaf_cnt = 0, query_cnt = 0, start_cnt = 0, best_cnt = 0, ack_cnt = 0;
  int node_last_idx = 0, node_t = 0, ent_last_addr = 0, ent_t = 0, start_t = 0;
  int best_last_addr = 0, best_t = 0;
  logic [21:0] node_last_data = '0;
  logic [63:0] ent_last_data = '0;
  always @(negedge clk) begin
    if (node_we) begin
      node_cnt <= node_cnt + 1; node_last_idx <= int'(node_idx);
      node_last_data <= node_wdata; node_t <= cyc_n;
    end
    if (leaf_we)  leaf_cnt  <= leaf_cnt + 1;
    if (query_we) query_cnt <= query_cnt + 1;
    if (leaf_we || query_we) begin
      ent_last_addr <= int'(entry_addr); ent_last_data <= entry_wdata; ent_t <= cyc_n;
    end
    if (start) begin start_cnt <= start_cnt + 1; start_t <= cyc_n; end
    if (best_re) begin best_cnt <= best_cnt + 1; best_last_addr <= int'(best_addr); best_t <= cyc_n; end
    if (ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_mode, m_debug, m_err, m_hvalid, m_hleaf;
  int          m_hidx;
  logic [31:0] m_hlo;

  typedef struct packed {
    int          lat;
    logic [31:0] rd;
    bit          node;
    int          node_idx;
    logic [21:0] node_data;
    bit          leaf;
    bit          query;
    int          ent_addr;
    logic [63:0] ent_data;
    bit          start;
    bit          best;
    int          best_addr;
  } exp_t;

  task automatic model_reset();
    m_mode = 0; m_debug = 0; m_err = 0; m_hvalid = 0; m_hleaf = 0; m_hidx = 0; m_hlo = '0;
  endtask

  task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d, output exp_t e);
    int region, off, idx, depth;
    bit half, leaf;
    e = '0;
    e.lat = 1;
    if (a[31:20] != 12'h300) return;
    region = int'((a >> 16) & 32'hF);
    half   = a[2];
    case (region)
      0: begin
        off = int'(a & 32'hFF);
        if (w) begin
          if (off == 0)  m_mode  = d[0];
          if (off == 4)  m_debug = d[0];
          if (off == 12 && !busy) e.start = 1;
          if (off == 20 && d[0]) m_err = 0;
        end else begin
          if (off == 0)  e.rd = {31'b0, m_mode};
          if (off == 4)  e.rd = {31'b0, m_debug};
          if (off == 8)  e.rd = {31'b0, done};
          if (off == 16) e.rd = {31'b0, busy};
          if (off == 20) e.rd = {31'b0, m_err};
        end
      end
      4: begin
        idx = int'((a >> 2) & 32'h3F);
        if (w && idx < 63) begin
          if (busy) m_err = 1;
          else begin e.node = 1; e.node_idx = idx; e.node_data = d[21:0]; end
        end
      end
      1, 2: begin
        leaf  = (region == 2);
        idx   = int'((a >> 3) & 32'h1FF);
        depth = leaf ? 512 : 494;
        if (w && idx < depth) begin
          if (busy) m_err = 1;
          else if (!half) begin
            m_hvalid = 1; m_hleaf = leaf; m_hidx = idx; m_hlo = d;
          end else if (m_hvalid && m_hidx == idx && m_hleaf == leaf) begin
            e.leaf = leaf; e.query = !leaf; e.ent_addr = idx; e.ent_data = {d, m_hlo};
            m_hvalid = 0;
          end else m_err = 1;
        end
      end
      3: begin
        if (!w) begin
          e.lat = 1 + LAT;
          idx = int'((a >> 3) & 32'h1FF);
          if (idx < 494) begin
            e.best = 1; e.best_addr = idx;
            e.rd = half ? best_mem[idx][63:32] : best_mem[idx][31:0];
          end
        end
      end
      default: ;
    endcase
  endtask

  // one Wishbone access; k = cycles from sampling edge to ack
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int k, output int t0);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d;
    t0 = cyc_n; k = 0; rd = '0;
    forever begin
      @(negedge clk);
      if (ack) begin rd = dat_o; break; end
      k++;
      if (k > 20) break;
    end
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic run(input bit w, input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
    exp_t e;
    int nn, nl, nq, ns, nb, k, t0;
    model(w, a, d, e);
    nn = node_cnt; nl = leaf_cnt; nq = query_cnt; ns = start_cnt; nb = best_cnt;
    xfer(w, a, d, rd, k, t0);
    chk("ack_lat", 64'(k), 64'(e.lat));
    if (!w) chk("rdata", 64'(rd), 64'(e.rd));
    chk("node_we_n", 64'(node_cnt - nn), 64'(e.node));
    if (e.node) begin
      chk("node_idx", 64'(node_last_idx), 64'(e.node_idx));
      chk("node_wdata", 64'(node_last_data), 64'(e.node_data));
      chk("node_t", 64'(node_t), 64'(t0 + 1));
    end
    chk("leaf_we_n", 64'(leaf_cnt - nl), 64'(e.leaf));
    chk("query_we_n", 64'(query_cnt - nq), 64'(e.query));
    if (e.leaf || e.query) begin
      chk("entry_addr", 64'(ent_last_addr), 64'(e.ent_addr));
      chk("entry_wdata", ent_last_data, e.ent_data);
      chk("entry_t", 64'(ent_t), 64'(t0 + 1));
    end
    chk("start_n", 64'(start_cnt - ns), 64'(e.start));
    if (e.start) chk("start_t", 64'(start_t), 64'(t0 + 1));
    chk("best_re_n", 64'(best_cnt - nb), 64'(e.best));
    if (e.best) begin
      chk("best_addr", 64'(best_last_addr), 64'(e.best_addr));
      chk("best_t", 64'(best_t), 64'(t0 + 1));
    end
    chk("mode_o", 64'(mode), 64'(m_mode));
    chk("debug_o", 64'(debug), 64'(m_debug));
  endtask

  function automatic logic [31:0] mk(input int region, input int off);
    return 32'h3000_0000 | (32'(region) << 16) | 32'(off);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int a0, n0, kind, region, idx, idx2, reg2;
    bit w;
    int ctrl_offs [7] = '{0, 4, 8, 12, 16, 20, 24};
    int rw_regions [3] = '{1, 2, 4};

    rst_n = 0; cyc = 0; stb = 0; we = 0; sel = 4'hF; adr = '0; dat_i = '0;
    busy = 0; done = 0;
    for (int i = 0; i < 512; i++) best_mem[i] = {$urandom, $urandom};
    best_mem[0] = 64'hAAAA_BBBB_CCCC_DDDD;
    model_reset();

    repeat (3) @(posedge clk); #1;
    chk("rst_ctrl_outs", 64'({ack, dat_o, mode, debug, start, node_we, leaf_we, query_we, best_re}), 64'd0);
    chk("rst_data_outs", 64'({node_idx, node_wdata, entry_addr, best_addr}), 64'd0);
    chk("rst_entry_wdata", entry_wdata, 64'd0);
    @(negedge clk); rst_n = 1;

    // node write
    run(1, 32'h3004_0004, {10'b0, 11'd55, 11'd1}, rd);
    chk("t2_node_idx", 64'(node_last_idx), 64'd1);
    chk("t2_node_wdata", 64'(node_last_data), 64'h1B801);

    // leaf entry from two halves
    run(1, 32'h3002_0018, 32'h1234_5678, rd);
    run(1, 32'h3002_001C, 32'h9ABC_DEF0, rd);
    chk("t3_leaf_cnt", 64'(leaf_cnt), 64'd1);
    chk("t3_entry_addr", 64'(ent_last_addr), 64'd3);
    chk("t3_entry_wdata", ent_last_data, 64'h9ABCDEF0_12345678);

    // sequence error on orphan upper half
    run(1, 32'h3001_0024, 32'h0000_0001, rd);
    chk("t4_query_cnt", 64'(query_cnt), 64'd0);
    run(0, 32'h3000_0014, 32'h0, rd);
    chk("t4_status_set", 64'(rd), 64'd1);
    run(1, 32'h3000_0014, 32'h1, rd);
    run(0, 32'h3000_0014, 32'h0, rd);
    chk("t4_status_clr", 64'(rd), 64'd0);

    // start and busy
    run(1, 32'h3000_000C, 32'h0, rd);
    busy = 1;
    run(1, 32'h3000_000C, 32'h0, rd);
    run(1, 32'h3002_0040, 32'h1111_1111, rd);
    run(1, 32'h3002_0044, 32'h2222_2222, rd);
    run(0, 32'h3000_0010, 32'h0, rd);
    run(0, 32'h3000_0014, 32'h0, rd);
    chk("t5_status_busy", 64'(rd), 64'd1);
    busy = 0;
    run(1, 32'h3000_0014, 32'h1, rd);

    // best read upper half
    run(0, 32'h3003_0004, 32'h0, rd);
    chk("t6_best_rdata", 64'(rd), 64'hAAAA_BBBB);
    run(0, 32'h3003_0000, 32'h0, rd);

    // RO write and out-of-range indices
    run(1, 32'h3000_0008, 32'h1, rd);
    run(1, mk(4, 63 << 2), 32'h3FFFFF, rd);
    run(0, mk(3, 500 << 3), 32'h0, rd);

    // master keeps stb high through recover with a new address
    a0 = ack_cnt;
    @(posedge clk); #1; cyc = 1; stb = 1; we = 0; adr = 32'h3000_0000;
    @(posedge clk); #1;
    @(posedge clk); #1; adr = 32'h3000_0004;
    @(posedge clk); #1; cyc = 0; stb = 0;
    repeat (3) @(posedge clk); #1;
    chk("recover_single_ack", 64'(ack_cnt - a0), 64'd1);

    // master drops stb before ack: write happens, ack suppressed
    a0 = ack_cnt; n0 = node_cnt;
    @(posedge clk); #1; cyc = 1; stb = 1; we = 1; adr = 32'h3004_0008; dat_i = 32'h7;
    @(posedge clk); #1; cyc = 0; stb = 0; we = 0;
    repeat (3) @(posedge clk); #1;
    chk("abort_no_ack", 64'(ack_cnt - a0), 64'd0);
    chk("abort_node_we", 64'(node_cnt - n0), 64'd1);
    chk("abort_node_idx", 64'(node_last_idx), 64'd2);

    // reset in the middle of a best read
    run(1, 32'h3002_0028, 32'hCAFE_0000, rd);
    run(1, 32'h3000_0000, 32'h1, rd);
    a0 = ack_cnt;
    @(posedge clk); #1; cyc = 1; stb = 1; we = 0; adr = 32'h3003_0008;
    @(negedge clk);
    @(negedge clk); #2; rst_n = 0;
    #1;
    chk("midrst_ctrl_outs", 64'({ack, dat_o, mode, debug, start, node_we, leaf_we, query_we, best_re}), 64'd0);
    chk("midrst_data_outs", 64'({node_idx, node_wdata, entry_addr, best_addr}), 64'd0);
    @(posedge clk); #1; cyc = 0; stb = 0;
    @(negedge clk); rst_n = 1;
    model_reset();
    repeat (3) @(posedge clk); #1;
    chk("midrst_no_ack", 64'(ack_cnt - a0), 64'd0);
    run(1, 32'h3002_002C, 32'h1, rd);
    run(0, 32'h3000_0014, 32'h0, rd);
    chk("midrst_hold_invalid", 64'(rd), 64'd1);
    run(1, 32'h3000_0014, 32'h1, rd);

    // randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      busy = ($urandom_range(0, 6) == 0);
      done = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      case (kind)
        0, 1: begin
          w = 1'($urandom_range(0, 1));
          run(w, mk(0, ctrl_offs[$urandom_range(0, 6)]), $urandom, rd);
        end
        2: run(1, mk(4, int'($urandom_range(0, 63)) << 2), $urandom, rd);
        3, 4, 5: begin
          region = int'($urandom_range(1, 2));
          idx = (region == 1) ? int'($urandom_range(0, 499)) : int'($urandom_range(0, 511));
          if ($urandom_range(0, 4) != 0) run(1, mk(region, idx << 3), $urandom, rd);
          idx2 = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 493)) : idx;
          reg2 = ($urandom_range(0, 7) == 0) ? 3 - region : region;
          run(1, mk(reg2, (idx2 << 3) | 4), $urandom, rd);
        end
        6, 7: begin
          idx = int'($urandom_range(0, 499));
          run(0, mk(3, (idx << 3) | (int'($urandom_range(0, 1)) << 2)), 32'h0, rd);
        end
        8: begin
          w = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 1) == 0) run(w, mk(int'($urandom_range(5, 15)), int'($urandom_range(0, 255)) << 2), $urandom, rd);
          else run(w, 32'h3010_0000 | (32'($urandom_range(0, 4)) << 16), $urandom, rd);
        end
        default: run(0, mk(rw_regions[$urandom_range(0, 2)], int'($urandom_range(0, 1023)) << 2), 32'h0, rd);
      endcase
    end
    busy = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
